// File: rtl/sync_arith_stim_gen.sv
// sync_arith_stim_gen: LFSR-driven operand generator and dual-ALU result checker (BIST initiator).
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start, i_hold           run start pulse (IDLE/DONE only), issue stall (RUN only)
//   o_arg_A, o_arg_B, o_op    operands/opcode to both ALUs, o_valid marks a new vector
//   i_result_*, i_status_*    model and gate-level ALU outputs to compare
//   o_test_cnt, o_err_cnt     compared / mismatching vector counts (saturating)
//   o_busy, o_done, o_pass    RUN|DRAIN, DONE, DONE with no errors
//   o_first_err_idx           first mismatching vector index, built only with STIM_ERR_LOG_EN
module sync_arith_stim_gen #(
    parameter int          BITS    = 32,
    parameter int          N_TESTS = 80,
    parameter int          LATENCY = 1,
    parameter logic [31:0] SEED_A  = 32'h0000_0001,
    parameter logic [31:0] SEED_B  = 32'h0000_0002
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_hold,
    output logic [BITS-1:0] o_arg_A,
    output logic [BITS-1:0] o_arg_B,
    output logic [1:0]      o_op,
    output logic            o_valid,
    input  logic [BITS-1:0] i_result_model,
    input  logic [BITS-1:0] i_result_gates,
    input  logic [3:0]      i_status_model,
    input  logic [3:0]      i_status_gates,
    output logic [15:0]     o_test_cnt,
    output logic [15:0]     o_err_cnt,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [15:0]     o_first_err_idx
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam logic [31:0] TAPS    = 32'h8020_0003;
    logic [1:0]         r_state;
    logic [31:0]        r_lfsr_a;
    logic [31:0]        r_lfsr_b;
    logic [15:0]        r_issue_cnt;
    logic [15:0]        r_test_cnt;
    logic [15:0]        r_err_cnt;
    logic [BITS-1:0]    r_arg_a;
    logic [BITS-1:0]    r_arg_b;
    logic [1:0]         r_op;
    // Stage 0 is o_valid itself, so the last stage lines up with the ALU result edge.
    logic [LATENCY-1:0] r_vpipe;
    logic               w_start;
    logic               w_issue;
    logic               w_cmp;
    logic               w_mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
    endfunction

    assign w_start    = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_issue    = r_state == S_RUN && !i_hold && r_issue_cnt != 16'(N_TESTS);
    assign w_cmp      = r_vpipe[LATENCY-1];
    // Case inequality so X/Z from either ALU is flagged in simulation.
    assign w_mismatch = (i_result_model !== i_result_gates) || (i_status_model !== i_status_gates);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_lfsr_a    <= SEED_A;
            r_lfsr_b    <= SEED_B;
            r_issue_cnt <= '0;
            r_test_cnt  <= '0;
            r_err_cnt   <= '0;
            r_arg_a     <= '0;
            r_arg_b     <= '0;
            r_op        <= '0;
            r_vpipe     <= '0;
        end else if (w_start) begin
            r_state     <= S_RUN;
            r_lfsr_a    <= SEED_A;
            r_lfsr_b    <= SEED_B;
            r_issue_cnt <= '0;
            r_test_cnt  <= '0;
            r_err_cnt   <= '0;
            r_vpipe     <= '0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | LATENCY'(w_issue);
            if (w_issue) begin
                r_arg_a     <= r_lfsr_a[BITS-1:0];
                r_arg_b     <= r_lfsr_b[BITS-1:0];
                r_op        <= r_lfsr_a[1:0] ^ r_lfsr_b[1:0];
                r_lfsr_a    <= lfsr_step(r_lfsr_a);
                r_lfsr_b    <= lfsr_step(r_lfsr_b);
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            if (w_cmp && r_test_cnt != 16'hFFFF)
                r_test_cnt <= r_test_cnt + 16'd1;
            if (w_cmp && w_mismatch && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (r_state == S_RUN && r_issue_cnt == 16'(N_TESTS))
                r_state <= S_DRAIN;
            else if (r_state == S_DRAIN && r_vpipe == '0)
                r_state <= S_DONE;
        end
    end

`ifdef STIM_ERR_LOG_EN
    logic [15:0] r_first_err;
    // The error counter saturates rather than wraps, so zero means no mismatch yet this run.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_start)
            r_first_err <= '0;
        else if (w_cmp && w_mismatch && r_err_cnt == 16'd0)
            r_first_err <= r_test_cnt;
    end
    assign o_first_err_idx = r_first_err;
`else
    assign o_first_err_idx = 16'd0;
`endif

    assign o_arg_A    = r_arg_a;
    assign o_arg_B    = r_arg_b;
    assign o_op       = r_op;
    assign o_valid    = r_vpipe[0];
    assign o_test_cnt = r_test_cnt;
    assign o_err_cnt  = r_err_cnt;
    assign o_busy     = r_state == S_RUN || r_state == S_DRAIN;
    assign o_done     = r_state == S_DONE;
    assign o_pass     = o_done && r_err_cnt == 16'd0;
endmodule

// File: tb/tb_sync_arith_stim_gen.sv
// tb_sync_arith_stim_gen: three generator instances (N=80/L=1, N=20/L=2, N=0/L=1) against a vector-list reference.
module tb_sync_arith_stim_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] hold = '0;
    logic [2:0][31:0] arg_a, arg_b, rm, rg;
    logic [2:0][3:0] sm, sg;
    logic [2:0][1:0] op;
    logic [2:0] valid, busy, done, pass, cor;
    logic [2:0][15:0] tcnt, ecnt, ferr;
    logic [31:0] ref_a [80];
    logic [31:0] ref_b [80];
    logic [1:0] ref_op [80];
    logic [31:0] q_r;
    logic [3:0] q_s;
    logic q_c;
    int inj_u = 0, inj_kind = 0, inj_idx = 0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_r(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        return o == 2'd0 ? a + b : o == 2'd1 ? a - b : o == 2'd2 ? a & b : a ^ b;
    endfunction

    function automatic logic [3:0] alu_s(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        logic [31:0] r;
        r = alu_r(a, b, o);
        return {r[31], r == 32'd0, a[31], b[0] ^ o[0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cor
        assign cor[g] = inj_kind != 0 && inj_u == g && valid[g] && arg_a[g] == ref_a[inj_idx] && arg_b[g] == ref_b[inj_idx];
    end

    always_ff @(posedge clk) begin
        q_r <= alu_r(arg_a[1], arg_b[1], op[1]);
        q_s <= alu_s(arg_a[1], arg_b[1], op[1]);
        q_c <= cor[1];
    end

    assign rm[0] = alu_r(arg_a[0], arg_b[0], op[0]);
    assign sm[0] = alu_s(arg_a[0], arg_b[0], op[0]);
    assign rm[1] = q_r;
    assign sm[1] = q_s;
    assign rm[2] = alu_r(arg_a[2], arg_b[2], op[2]);
    assign sm[2] = alu_s(arg_a[2], arg_b[2], op[2]);
    assign rg[0] = rm[0] ^ {31'd0, inj_kind == 2 && cor[0]};
    assign sg[0] = sm[0] ^ {3'd0, inj_kind == 1 && cor[0]};
    assign rg[1] = rm[1] ^ {31'd0, inj_kind == 2 && q_c};
    assign sg[1] = sm[1] ^ {3'd0, inj_kind == 1 && q_c};
    assign rg[2] = rm[2];
    assign sg[2] = sm[2];

    sync_arith_stim_gen #(.N_TESTS(80), .LATENCY(1)) u0 (
        .i_clk(clk), .i_reset(reset), .i_start(start[0]), .i_hold(hold[0]),
        .o_arg_A(arg_a[0]), .o_arg_B(arg_b[0]), .o_op(op[0]), .o_valid(valid[0]),
        .i_result_model(rm[0]), .i_result_gates(rg[0]), .i_status_model(sm[0]), .i_status_gates(sg[0]),
        .o_test_cnt(tcnt[0]), .o_err_cnt(ecnt[0]), .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_first_err_idx(ferr[0]));

    sync_arith_stim_gen #(.N_TESTS(20), .LATENCY(2)) u1 (
        .i_clk(clk), .i_reset(reset), .i_start(start[1]), .i_hold(hold[1]),
        .o_arg_A(arg_a[1]), .o_arg_B(arg_b[1]), .o_op(op[1]), .o_valid(valid[1]),
        .i_result_model(rm[1]), .i_result_gates(rg[1]), .i_status_model(sm[1]), .i_status_gates(sg[1]),
        .o_test_cnt(tcnt[1]), .o_err_cnt(ecnt[1]), .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_first_err_idx(ferr[1]));

    sync_arith_stim_gen #(.N_TESTS(0), .LATENCY(1)) u2 (
        .i_clk(clk), .i_reset(reset), .i_start(start[2]), .i_hold(hold[2]),
        .o_arg_A(arg_a[2]), .o_arg_B(arg_b[2]), .o_op(op[2]), .o_valid(valid[2]),
        .i_result_model(rm[2]), .i_result_gates(rg[2]), .i_status_model(sm[2]), .i_status_gates(sg[2]),
        .o_test_cnt(tcnt[2]), .o_err_cnt(ecnt[2]), .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]),
        .o_first_err_idx(ferr[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int u, input string tag);
        chk({tag, " arg_A"}, arg_a[u], 32'd0);
        chk({tag, " arg_B"}, arg_b[u], 32'd0);
        chk({tag, " op"}, 32'(op[u]), 32'd0);
        chk({tag, " valid"}, 32'(valid[u]), 32'd0);
        chk({tag, " test_cnt"}, 32'(tcnt[u]), 32'd0);
        chk({tag, " err_cnt"}, 32'(ecnt[u]), 32'd0);
        chk({tag, " busy"}, 32'(busy[u]), 32'd0);
        chk({tag, " done"}, 32'(done[u]), 32'd0);
        chk({tag, " pass"}, 32'(pass[u]), 32'd0);
        chk({tag, " first_err"}, 32'(ferr[u]), 32'd0);
    endtask

    // mode 0: no hold, 1: hold on edges 7..16, 2: random hold and ignored start pulses
    task automatic run(input int u, input int mode, input int kind, input int idx);
        int n, l, issued, c_last, done_at, exp_done, exp_first;
        logic h, pred;
        n = u == 0 ? 80 : u == 1 ? 20 : 0;
        l = u == 1 ? 2 : 1;
        inj_u = u;
        inj_kind = kind;
        inj_idx = idx;
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        chk($sformatf("u%0d start busy", u), 32'(busy[u]), 32'd1);
        chk($sformatf("u%0d start test_cnt", u), 32'(tcnt[u]), 32'd0);
        chk($sformatf("u%0d start err_cnt", u), 32'(ecnt[u]), 32'd0);
        issued = 0;
        c_last = 0;
        done_at = -1;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            h = mode == 1 ? (c >= 7 && c <= 16) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            hold[u] = h;
            start[u] = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            pred = issued < n && !h;
            chk($sformatf("u%0d valid edge %0d", u, c), 32'(valid[u]), 32'(pred));
            if (pred) begin
                chk($sformatf("u%0d vec%0d A", u, issued), arg_a[u], ref_a[issued]);
                chk($sformatf("u%0d vec%0d B", u, issued), arg_b[u], ref_b[issued]);
                chk($sformatf("u%0d vec%0d op", u, issued), 32'(op[u]), 32'(ref_op[issued]));
                issued++;
                c_last = c;
            end
            if (done[u]) done_at = c;
        end
        hold[u] = 1'b0;
        start[u] = 1'b0;
        exp_done = n == 0 ? 2 : c_last + l + 1;
`ifdef STIM_ERR_LOG_EN
        exp_first = kind != 0 ? idx : 0;
`else
        exp_first = 0;
`endif
        chk($sformatf("u%0d m%0d done edge", u, mode), done_at, exp_done);
        if (mode == 1) chk("u1 hold done edge", done_at, 33);
        chk($sformatf("u%0d m%0d issued", u, mode), issued, n);
        chk($sformatf("u%0d m%0d test_cnt", u, mode), 32'(tcnt[u]), n);
        chk($sformatf("u%0d m%0d err_cnt", u, mode), 32'(ecnt[u]), kind != 0 ? 1 : 0);
        chk($sformatf("u%0d m%0d pass", u, mode), 32'(pass[u]), kind != 0 ? 0 : 1);
        chk($sformatf("u%0d m%0d busy", u, mode), 32'(busy[u]), 32'd0);
        chk($sformatf("u%0d m%0d first_err", u, mode), 32'(ferr[u]), exp_first);
        tick();
        chk($sformatf("u%0d m%0d done holds", u, mode), 32'(done[u]), 32'd1);
        inj_kind = 0;
    endtask

    initial begin
        logic [31:0] la, lb;
        int cnt;
        la = 32'h0000_0001;
        lb = 32'h0000_0002;
        for (int k = 0; k < 80; k++) begin
            ref_a[k] = la;
            ref_b[k] = lb;
            ref_op[k] = la[1:0] ^ lb[1:0];
            la = (la >> 1) ^ (la[0] ? 32'h8020_0003 : 32'h0);
            lb = (lb >> 1) ^ (lb[0] ? 32'h8020_0003 : 32'h0);
        end
        tick();
        tick();
        reset = 1'b0;
        chk_zero(0, "reset u0");
        chk_zero(1, "reset u1");
        chk_zero(2, "reset u2");
        run(0, 0, 0, 0);
        run(0, 0, 1, 5);
        run(0, 0, 2, int'($urandom_range(0, 79)));
        run(1, 0, 0, 0);
        run(1, 1, 0, 0);
        run(1, 2, int'($urandom_range(1, 2)), int'($urandom_range(0, 19)));
        run(2, 0, 0, 0);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 20; c++) begin
            tick();
            if (valid[1]) cnt++;
        end
        chk("drain vectors seen", cnt, 20);
        tick();
        chk("drain busy", 32'(busy[1]), 32'd1);
        chk("drain done", 32'(done[1]), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero(1, "reset in drain");
        run(1, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
